// File: rtl/rvm_adder_arbiter_pkg.sv
// rvm_adder_arbiter_pkg: arith op codes, requester ids and helpers shared by the adder arbiter.
package rvm_adder_arbiter_pkg;
    typedef enum logic [2:0] {
        RVM_ARITH_NOP = 3'd0,
        RVM_ARITH_ADD = 3'd1,
        RVM_ARITH_SUB = 3'd2
    } rvm_arith_op_e;
    localparam int RVM_ADDREQ_N = 3;
    localparam logic [1:0] RVM_ADDREQ_FETCH = 2'd0;
    localparam logic [1:0] RVM_ADDREQ_EXEC = 2'd1;
    localparam logic [1:0] RVM_ADDREQ_LSU = 2'd2;
    typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_e;
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == RVM_ADDREQ_LSU) ? RVM_ADDREQ_FETCH : p + 2'd1;
    endfunction
    function automatic logic op_defined(input logic [2:0] op);
        return op inside {RVM_ARITH_NOP, RVM_ARITH_ADD, RVM_ARITH_SUB};
    endfunction
endpackage

// File: rtl/rvm_adder_arbiter_if.sv
// rvm_adder_arbiter_if: request and response handshake bundle between requesters, consumer and arbiter.
interface rvm_adder_arbiter_if;
    import rvm_adder_arbiter_pkg::*;
    logic [RVM_ADDREQ_N-1:0] req_valid;
    logic [RVM_ADDREQ_N-1:0] req_ready;
    logic [RVM_ADDREQ_N-1:0][2:0] req_op;
    logic [RVM_ADDREQ_N-1:0][31:0] req_lhs;
    logic [RVM_ADDREQ_N-1:0][31:0] req_rhs;
    logic rsp_valid;
    logic rsp_ready;
    logic [1:0] rsp_id;
    logic [32:0] rsp_result;
    logic rsp_err;
    modport master (
        output req_valid, req_op, req_lhs, req_rhs, rsp_ready,
        input req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
    modport slave (
        input req_valid, req_op, req_lhs, req_rhs, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/rvm_adder.sv
// rvm_adder: 33-bit add/sub unit; bit 32 is carry on ADD and borrow on SUB, other ops yield zero.
module rvm_adder
    import rvm_adder_arbiter_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    output logic [32:0] result
);
    always_comb
        result = (op == RVM_ARITH_ADD) ? {1'b0, lhs} + {1'b0, rhs} :
                 (op == RVM_ARITH_SUB) ? {1'b0, lhs} - {1'b0, rhs} : 33'd0;
endmodule

// File: rtl/rvm_rr_arb3.sv
// rvm_rr_arb3: combinational 3-way round-robin priority encoder, scanning ptr, ptr+1, ptr+2.
module rvm_rr_arb3
    import rvm_adder_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);
    logic [1:0] p1, p2;
    assign p1 = rr_next(ptr);
    assign p2 = rr_next(p1);
    assign grant = req[ptr] ? 3'b001 << ptr :
                   req[p1]  ? 3'b001 << p1  :
                   req[p2]  ? 3'b001 << p2  : 3'b000;
endmodule

// File: rtl/rvm_adder_arbiter.sv
// rvm_adder_arbiter: round-robin sharing of one rvm_adder between fetch, execute and LSU,
// with a single registered response slot that accepts a new result while the old one drains.
module rvm_adder_arbiter
    import rvm_adder_arbiter_pkg::*;
#(
    parameter int NREQ = RVM_ADDREQ_N,
    parameter int RESET_PTR = 0
) (
    input logic clk,
    input logic reset,
    rvm_adder_arbiter_if.slave bus
);
    arb_state_e state;
    logic [1:0] ptr, gid;
    logic [NREQ-1:0] arb_grant, grant;
    logic can_grant, hs;
    logic [2:0] add_op;
    logic [31:0] add_lhs, add_rhs;
    logic [32:0] add_result;
    rvm_rr_arb3 u_arb (.req(bus.req_valid), .ptr(ptr), .grant(arb_grant));
    assign can_grant = !reset && (state == ARB_EMPTY || bus.rsp_ready);
    assign grant = can_grant ? arb_grant : '0;
    assign hs = |grant;
    assign gid = grant[2] ? RVM_ADDREQ_LSU : grant[1] ? RVM_ADDREQ_EXEC : RVM_ADDREQ_FETCH;
    // Idle adder sees NOP and zero operands so it does not toggle without a handshake.
    assign add_op = hs ? bus.req_op[gid] : RVM_ARITH_NOP;
    assign add_lhs = hs ? bus.req_lhs[gid] : 32'd0;
    assign add_rhs = hs ? bus.req_rhs[gid] : 32'd0;
    rvm_adder u_adder (.op(add_op), .lhs(add_lhs), .rhs(add_rhs), .result(add_result));
    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == ARB_FULL);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_EMPTY;
            ptr <= 2'(RESET_PTR);
            bus.rsp_id <= 2'd0;
            bus.rsp_result <= 33'd0;
            bus.rsp_err <= 1'b0;
        end else if (hs) begin
            state <= ARB_FULL;
            ptr <= rr_next(gid);
            bus.rsp_id <= gid;
            bus.rsp_result <= add_result;
            bus.rsp_err <= !op_defined(add_op);
        end else if (bus.rsp_ready) begin
            state <= ARB_EMPTY;
        end
    end
endmodule

// File: tb/tb_rvm_adder_arbiter.sv
// tb_rvm_adder_arbiter: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_rvm_adder_arbiter;
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    logic clk = 1'b0;
    logic reset;
    int passed = 0;
    int total = 0;
    logic m_valid;
    logic [1:0] m_id;
    logic [32:0] m_res;
    logic m_err;
    int m_ptr;
    always #5 clk = ~clk;
    rvm_adder_arbiter_if bus();
    rvm_adder_arbiter #(.NREQ(3), .RESET_PTR(0)) dut (.clk(clk), .reset(reset), .bus(bus));
    function automatic logic [2:0] m_grant();
        if (reset || (m_valid && !bus.rsp_ready)) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_ptr + k) % 3;
            if (bus.req_valid[idx]) return 3'(1 << idx);
        end
        return 3'b000;
    endfunction
    function automatic logic [32:0] m_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (op == OP_ADD) return 33'(x + y);
        if (op == OP_SUB) return 33'(x - y);
        return 33'd0;
    endfunction
    task automatic tick();
        logic [2:0] g;
        logic [1:0] gi;
        g = m_grant();
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_id = 2'd0; m_res = 33'd0; m_err = 1'b0; m_ptr = 0;
        end else if (g != 3'b000) begin
            gi = g[0] ? 2'd0 : g[1] ? 2'd1 : 2'd2;
            m_valid = 1'b1;
            m_id = gi;
            m_res = m_calc(bus.req_op[gi], bus.req_lhs[gi], bus.req_rhs[gi]);
            m_err = bus.req_op[gi] > OP_SUB;
            m_ptr = (int'(gi) + 1) % 3;
        end else if (bus.rsp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask
    task automatic drive(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[i] = op;
        bus.req_lhs[i] = a;
        bus.req_rhs[i] = b;
        bus.req_valid[i] = 1'b1;
    endtask
    task automatic clear();
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_lhs = '0;
        bus.req_rhs = '0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        clear();
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        bus.req_valid = 3'b111;
        bus.rsp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 3'b000) $display("FAIL reset_req_ready got=%b exp=000", bus.req_ready); else passed++;
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); else passed++;
        total++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); else passed++;
        total++; if (bus.rsp_result !== 33'd0) $display("FAIL reset_rsp_result got=%h exp=0", bus.rsp_result); else passed++;
        total++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); else passed++;
        tick();
        reset = 1'b0;
        clear();
    endtask
    task automatic test_single();
        bus.rsp_ready = 1'b1;
        drive(1, OP_ADD, 32'd5, 32'd7);
        #1;
        total++; if (bus.req_ready !== 3'b010) $display("FAIL single_grant got=%b exp=010", bus.req_ready); else passed++;
        tick();
        clear();
        #1;
        total++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); else passed++;
        total++; if (bus.rsp_id !== 2'd1) $display("FAIL single_rsp_id got=%0d exp=1", bus.rsp_id); else passed++;
        total++; if (bus.rsp_result !== 33'd12) $display("FAIL single_rsp_result got=%h exp=%h", bus.rsp_result, 33'd12); else passed++;
        total++; if (bus.rsp_err !== 1'b0) $display("FAIL single_rsp_err got=%b exp=0", bus.rsp_err); else passed++;
        tick();
        #1;
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", bus.rsp_valid); else passed++;
    endtask
    task automatic test_carry_borrow();
        drive(2, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        #1;
        total++; if (bus.req_ready !== 3'b100) $display("FAIL carry_grant got=%b exp=100", bus.req_ready); else passed++;
        tick();
        drive(2, OP_SUB, 32'd0, 32'd1);
        #1;
        total++; if (bus.rsp_result !== 33'h1_0000_0000) $display("FAIL carry_result got=%h exp=100000000", bus.rsp_result); else passed++;
        total++; if (bus.req_ready !== 3'b100) $display("FAIL borrow_b2b_grant got=%b exp=100", bus.req_ready); else passed++;
        tick();
        clear();
        #1;
        total++; if (bus.rsp_result !== 33'h1_FFFF_FFFF) $display("FAIL borrow_result got=%h exp=1ffffffff", bus.rsp_result); else passed++;
        total++; if (bus.rsp_id !== 2'd2) $display("FAIL borrow_rsp_id got=%0d exp=2", bus.rsp_id); else passed++;
        tick();
    endtask
    task automatic test_round_robin();
        for (int i = 0; i < 3; i++) drive(i, OP_ADD, $urandom, $urandom);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++; if (bus.req_ready !== 3'(1 << (k % 3))) $display("FAIL rr_grant step=%0d got=%b exp=%b", k, bus.req_ready, 3'(1 << (k % 3))); else passed++;
            if (k > 0) begin
                total++; if (bus.rsp_id !== 2'((k - 1) % 3)) $display("FAIL rr_rsp_id step=%0d got=%0d exp=%0d", k, bus.rsp_id, (k - 1) % 3); else passed++;
            end
            tick();
        end
        #1;
        total++; if (bus.rsp_id !== 2'd2 || bus.rsp_result !== m_res) $display("FAIL rr_last got=%0d/%h exp=2/%h", bus.rsp_id, bus.rsp_result, m_res); else passed++;
    endtask
    task automatic test_backpressure();
        logic [32:0] held;
        clear();
        drive(0, OP_ADD, $urandom, $urandom);
        #1;
        total++; if (bus.req_ready !== 3'b001) $display("FAIL bp_first_grant got=%b exp=001", bus.req_ready); else passed++;
        tick();
        held = m_res;
        clear();
        drive(2, OP_SUB, $urandom, $urandom);
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (bus.req_ready !== 3'b000) $display("FAIL bp_req_ready cyc=%0d got=%b exp=000", k, bus.req_ready); else passed++;
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_result !== held) $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h exp=1/0/%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, held); else passed++;
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 3'b100) $display("FAIL bp_release_grant got=%b exp=100", bus.req_ready); else passed++;
        tick();
        clear();
        #1;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_result !== m_res) $display("FAIL bp_release_rsp got=%b/%0d/%h exp=1/2/%h", bus.rsp_valid, bus.rsp_id, bus.rsp_result, m_res); else passed++;
    endtask
    task automatic test_undef_op();
        drive(0, 3'b011, $urandom, $urandom);
        #1;
        total++; if (bus.req_ready !== 3'b001) $display("FAIL undef_grant got=%b exp=001", bus.req_ready); else passed++;
        tick();
        clear();
        #1;
        total++; if (bus.rsp_err !== 1'b1 || bus.rsp_result !== 33'd0 || bus.rsp_id !== 2'd0) $display("FAIL undef_rsp got=%b/%h/%0d exp=1/0/0", bus.rsp_err, bus.rsp_result, bus.rsp_id); else passed++;
        for (int i = 0; i < 3; i++) drive(i, OP_NOP, $urandom, $urandom);
        #1;
        total++; if (bus.req_ready !== 3'b010) $display("FAIL undef_ptr_advance got=%b exp=010", bus.req_ready); else passed++;
        tick();
        clear();
        #1;
        total++; if (bus.rsp_err !== 1'b0 || bus.rsp_result !== 33'd0 || bus.rsp_id !== 2'd1) $display("FAIL nop_rsp got=%b/%h/%0d exp=0/0/1", bus.rsp_err, bus.rsp_result, bus.rsp_id); else passed++;
        tick();
    endtask
    task automatic test_random();
        logic [2:0] exp_g;
        int r;
        clear();
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) != 0) begin
                    r = $urandom_range(0, 9);
                    drive(i, r < 4 ? OP_ADD : r < 8 ? OP_SUB : r == 8 ? OP_NOP : 3'($urandom_range(3, 7)),
                          $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom,
                          $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom);
                end
            end
            bus.rsp_ready = $urandom_range(0, 3) != 0;
            #1;
            exp_g = m_grant();
            total++; if (bus.req_ready !== exp_g) $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_g); else passed++;
            total++; if (bus.rsp_valid !== m_valid) $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", c, bus.rsp_valid, m_valid); else passed++;
            if (m_valid) begin
                total++; if (bus.rsp_id !== m_id || bus.rsp_result !== m_res || bus.rsp_err !== m_err) $display("FAIL rand_rsp cyc=%0d got=%0d/%h/%b exp=%0d/%h/%b", c, bus.rsp_id, bus.rsp_result, bus.rsp_err, m_id, m_res, m_err); else passed++;
            end
            tick();
            for (int i = 0; i < 3; i++) if (exp_g[i]) bus.req_valid[i] = 1'b0;
        end
        clear();
    endtask
    task automatic test_reset_mid();
        bus.rsp_ready = 1'b1;
        drive(1, OP_ADD, $urandom, $urandom);
        tick();
        clear();
        drive(2, OP_SUB, $urandom, $urandom);
        bus.rsp_ready = 1'b0;
        #1;
        total++; if (bus.rsp_valid !== 1'b1) $display("FAIL mid_full got=%b exp=1", bus.rsp_valid); else passed++;
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 3'b000) $display("FAIL mid_req_ready got=%b exp=000", bus.req_ready); else passed++;
        tick();
        reset = 1'b0;
        clear();
        #1;
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got=%b exp=0", bus.rsp_valid); else passed++;
        for (int i = 0; i < 3; i++) drive(i, OP_ADD, $urandom, $urandom);
        #1;
        total++; if (bus.req_ready !== 3'b001) $display("FAIL mid_first_grant got=%b exp=001", bus.req_ready); else passed++;
        tick();
        clear();
        #1;
        total++; if (bus.rsp_id !== 2'd0 || bus.rsp_result !== m_res) $display("FAIL mid_first_rsp got=%0d/%h exp=0/%h", bus.rsp_id, bus.rsp_result, m_res); else passed++;
    endtask
    initial begin
        test_reset();
        test_single();
        test_carry_borrow();
        test_round_robin();
        test_backpressure();
        test_undef_op();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
